serial_word_feeder: RTL

//  Upstream feeder for the 4-bit bidirectional shift register. Accepts a parallel word with a

---
 rtl/serial_word_feeder.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// Serialises a parallel word into a bidirectional shift register's Data_in/MODE pins,
// then pads with FLUSH cycles so the word can be observed on that register's serial output.
//
// state  | meaning
// IDLE   | load_ready high; ser_data at PAD_BIT, ser_mode holds last frame's direction
// SHIFT  | one data bit per clock on ser_data, ser_valid high
// FLUSH  | FLUSH pad cycles on ser_data, ser_valid low
module serial_word_feeder #(
    parameter int   WIDTH   = 4,
    parameter int   FLUSH   = 4,
    parameter logic PAD_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             ser_data,
    output logic             ser_mode,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int MAX_CNT = (WIDTH > FLUSH) ? WIDTH : FLUSH;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((FLUSH > 0) ? FLUSH - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word, word_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             mode_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            word     <= '0;
            count    <= '0;
            ser_mode <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            word     <= word_nxt;
            count    <= count_nxt;
            ser_mode <= mode_nxt;
            done     <= done_nxt;
        end
    end

    // count is a down-counter reloaded on every state change; zero marks the last cycle
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        count_nxt = count;
        mode_nxt  = ser_mode;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
                    state_nxt = ST_SHIFT;
                    word_nxt  = load_data;
                    mode_nxt  = load_dir;
                    count_nxt = SHIFT_LAST;
                end
            end
            ST_SHIFT: begin
                word_nxt = ser_mode ? (word << 1) : (word >> 1);
                if (count == '0) begin
                    if (FLUSH > 0) begin
                        state_nxt = ST_FLUSH;
                        count_nxt = FLUSH_LAST;
                    end else begin
                        state_nxt = ST_IDLE;
                        count_nxt = '0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            ST_FLUSH: begin
                if (count == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign load_ready = (state == ST_IDLE);
    assign ser_valid  = (state == ST_SHIFT);
    assign busy       = (state == ST_SHIFT) || (state == ST_FLUSH);
    // MSB leaves first when shifting toward bit WIDTH-1 so the word lands in place downstream
    assign ser_data   = ser_valid ? (ser_mode ? word[WIDTH-1] : word[0]) : PAD_BIT;

endmodule
